// File: rtl/rst_sequencer_if.sv
// rst_sequencer_if: reset request and lock inputs plus sequenced reset outputs
interface rst_sequencer_if #(
   parameter int NCHAN = 4
);
   logic             trigger_reset;
   logic             pll_locked;
   logic             wdt_kick;
   logic [NCHAN-1:0] rst_out;
   logic             done;
   logic             wdt_fired;
   modport master (input trigger_reset, pll_locked, wdt_kick, output rst_out, done, wdt_fired);
   modport slave (output trigger_reset, pll_locked, wdt_kick, input rst_out, done, wdt_fired);
endinterface

// File: rtl/rst_sequencer.sv
// rst_sequencer: holds resets until PLL lock is stable, then releases them in index order;
// defining RST_SEQ_WATCHDOG_EN adds a RUN-state watchdog that re-aborts the sequence.
module rst_sequencer #(
   parameter int NCHAN       = 4,
   parameter int CW          = 20,
   parameter int HOLD_CYCLES = 20'hFFFFF,
   parameter int STAGE_GAP   = 128,
   parameter int WDT_CYCLES  = 24'hFFFFFF
) (
   input logic             sys_clk,
   input logic             sys_rst_n,
   rst_sequencer_if.master bus
);
   localparam int IW = NCHAN > 1 ? $clog2(NCHAN) : 1;
   localparam logic [CW-1:0] HOLD_LD = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GAP_LD = CW'(STAGE_GAP - 1);
   localparam logic [IW-1:0] LAST = IW'(NCHAN - 1);
   typedef enum logic [1:0] {ASSERT, HOLD, RELEASE, RUN} state_t;
   state_t           state, state_d;
   logic [CW-1:0]    cnt, cnt_d;
   logic [IW-1:0]    idx, idx_d;
   logic [NCHAN-1:0] rst_q, rst_d;
   logic             done_q, done_d;
   logic             lock_m, lock_s;
   logic             wdt_exp, abort;
   assign abort = bus.trigger_reset | ~lock_s | wdt_exp;
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         state  <= ASSERT;
         cnt    <= '0;
         idx    <= '0;
         rst_q  <= '1;
         done_q <= 1'b0;
         lock_m <= 1'b0;
         lock_s <= 1'b0;
      end else begin
         state  <= state_d;
         cnt    <= cnt_d;
         idx    <= idx_d;
         rst_q  <= rst_d;
         done_q <= done_d;
         lock_m <= bus.pll_locked;
         lock_s <= lock_m;
      end
   always_comb begin
      state_d = state;
      cnt_d   = cnt;
      idx_d   = idx;
      rst_d   = rst_q;
      done_d  = done_q;
      if (abort) begin
         state_d = ASSERT;
         idx_d   = '0;
         rst_d   = '1;
         done_d  = 1'b0;
      end else begin
         case (state)
            ASSERT: begin
               state_d = HOLD;
               cnt_d   = HOLD_LD;
            end
            HOLD: begin
               if (cnt != '0) cnt_d = cnt - 1'b1;
               else begin
                  rst_d[0] = 1'b0;
                  idx_d    = IW'(1);
                  cnt_d    = GAP_LD;
                  state_d  = NCHAN == 1 ? RUN : RELEASE;
                  done_d   = NCHAN == 1;
               end
            end
            RELEASE: begin
               if (cnt != '0) cnt_d = cnt - 1'b1;
               else begin
                  rst_d[idx] = 1'b0;
                  cnt_d      = GAP_LD;
                  state_d    = idx == LAST ? RUN : RELEASE;
                  done_d     = idx == LAST;
                  idx_d      = idx == LAST ? idx : idx + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end
`ifdef RST_SEQ_WATCHDOG_EN
   localparam int WW = WDT_CYCLES > 1 ? $clog2(WDT_CYCLES) : 1;
   logic [WW-1:0] wdt;
   logic          fired;
   // a kick on the expiry cycle suppresses the abort
   assign wdt_exp = state == RUN && !bus.wdt_kick && wdt == WW'(WDT_CYCLES - 1);
   always_ff @(posedge sys_clk or negedge sys_rst_n)
      if (!sys_rst_n) begin
         wdt   <= '0;
         fired <= 1'b0;
      end else begin
         wdt   <= (bus.wdt_kick || state != RUN) ? '0 : wdt + 1'b1;
         fired <= fired | wdt_exp;
      end
   assign bus.wdt_fired = fired;
`else
   logic unused_ok;
   assign unused_ok     = ^{bus.wdt_kick, WDT_CYCLES[0]};
   assign wdt_exp       = 1'b0;
   assign bus.wdt_fired = 1'b0;
`endif
   assign bus.rst_out = rst_q;
   assign bus.done    = done_q;
endmodule

// File: tb/tb_rst_sequencer.sv
// tb_rst_sequencer: vector table, corner sequences and randomized model comparison
`timescale 1ns/1ps
module tb_rst_sequencer;
   localparam int HOLD = 8, GAP = 4, WDT = 16, NV = 31;
`ifdef RST_SEQ_WATCHDOG_EN
   localparam bit WD_EN = 1'b1;
`else
   localparam bit WD_EN = 1'b0;
`endif
   typedef struct {int n; bit t; bit p; logic [2:0] r3; logic d3; logic r1; logic d1;} vec_t;
   typedef struct {bit in_a; int n; int wclr; bit fired;} mst_t;
   logic sys_clk = 1'b0, sys_rst_n = 1'b0, trig = 1'b0, pll = 1'b0, kick = 1'b0;
   int vectors = 0, miscompares = 0;
   rst_sequencer_if #(.NCHAN(3)) b3();
   rst_sequencer_if #(.NCHAN(1)) b1();
   assign b3.trigger_reset = trig;
   assign b3.pll_locked    = pll;
   assign b3.wdt_kick      = kick;
   assign b1.trigger_reset = trig;
   assign b1.pll_locked    = pll;
   assign b1.wdt_kick      = kick;
   rst_sequencer #(.NCHAN(3), .CW(8), .HOLD_CYCLES(HOLD), .STAGE_GAP(GAP), .WDT_CYCLES(WDT))
      u3 (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(b3));
   rst_sequencer #(.NCHAN(1), .CW(4), .HOLD_CYCLES(1), .STAGE_GAP(1), .WDT_CYCLES(WDT))
      u1 (.sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .bus(b1));
   always #5 sys_clk = ~sys_clk;

   task automatic step();
      @(posedge sys_clk);
      #1;
   endtask

   task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s @%0t: got %0h expected %0h", nm, $time, act, exp);
      end
   endtask

   task automatic chk_all(string nm, logic [2:0] r3, logic d3, logic r1, logic d1, logic f3, logic f1);
      chk({nm, ".rst3"}, 32'(b3.rst_out), 32'(r3));
      chk({nm, ".done3"}, 32'(b3.done), 32'(d3));
      chk({nm, ".rst1"}, 32'(b1.rst_out), 32'(r1));
      chk({nm, ".done1"}, 32'(b1.done), 32'(d1));
      chk({nm, ".fired3"}, 32'(b3.wdt_fired), 32'(f3));
      chk({nm, ".fired1"}, 32'(b1.wdt_fired), 32'(f1));
   endtask

   task automatic wait_done(string nm);
      int k = 0;
      while (!b3.done && k < 100) begin
         step();
         k++;
      end
      chk(nm, 32'(b3.done), 32'd1);
   endtask

   // reference: count edges since leaving ASSERT; channel k is free once that count reaches HOLD+k*GAP
   function automatic bit mdone(mst_t s, int nch, int hold, int gap);
      return !s.in_a && s.n >= hold + (nch - 1) * gap;
   endfunction

   function automatic logic [2:0] mrst(mst_t s, int nch, int hold, int gap);
      logic [2:0] r = '0;
      for (int k = 0; k < nch; k++) r[k] = s.in_a || s.n < hold + k * gap;
      return r;
   endfunction

   function automatic mst_t mstep(mst_t s, bit ab, bit kk, int e, int nch, int hold, int gap);
      mst_t r = s;
      bit run = mdone(s, nch, hold, gap);
      bit ex = WD_EN && run && !kk && (e - s.wclr == WDT);
      if (ab || ex) r.in_a = 1'b1;
      else if (s.in_a) begin
         r.in_a = 1'b0;
         r.n = 0;
      end else if (r.n < 100000) r.n++;
      if (kk || (!run && mdone(r, nch, hold, gap))) r.wclr = e;
      r.fired = s.fired | ex;
      return r;
   endfunction

   initial begin
      vec_t tbl [NV];
      mst_t m3, m1;
      logic [2:0] e3;
      logic p1, p2;
      bit ab;
      int e = 0;
      tbl = '{
         '{3, 0, 1, 3'b111, 0, 1, 0}, '{1, 0, 1, 3'b111, 0, 0, 1}, '{6, 0, 1, 3'b111, 0, 0, 1},
         '{1, 0, 1, 3'b110, 0, 0, 1}, '{3, 0, 1, 3'b110, 0, 0, 1}, '{1, 0, 1, 3'b100, 0, 0, 1},
         '{3, 0, 1, 3'b100, 0, 0, 1}, '{1, 0, 1, 3'b000, 1, 0, 1}, '{5, 0, 1, 3'b000, 1, 0, 1},
         '{1, 1, 1, 3'b111, 0, 1, 0}, '{1, 0, 1, 3'b111, 0, 1, 0}, '{1, 0, 1, 3'b111, 0, 0, 1},
         '{6, 0, 1, 3'b111, 0, 0, 1}, '{1, 0, 1, 3'b110, 0, 0, 1}, '{2, 0, 1, 3'b110, 0, 0, 1},
         '{1, 1, 1, 3'b111, 0, 1, 0}, '{1, 0, 1, 3'b111, 0, 1, 0}, '{8, 0, 1, 3'b110, 0, 0, 1},
         '{4, 0, 1, 3'b100, 0, 0, 1}, '{4, 0, 1, 3'b000, 1, 0, 1}, '{2, 0, 0, 3'b000, 1, 0, 1},
         '{1, 0, 0, 3'b111, 0, 1, 0}, '{5, 0, 0, 3'b111, 0, 1, 0}, '{3, 0, 1, 3'b111, 0, 1, 0},
         '{1, 0, 1, 3'b111, 0, 0, 1}, '{7, 0, 1, 3'b110, 0, 0, 1}, '{4, 0, 1, 3'b100, 0, 0, 1},
         '{4, 0, 1, 3'b000, 1, 0, 1}, '{20, 1, 1, 3'b111, 0, 1, 0}, '{1, 0, 1, 3'b111, 0, 1, 0},
         '{8, 0, 1, 3'b110, 0, 0, 1}};
      pll = 1'b1;
      kick = 1'b1;
      repeat (2) step();
      chk_all("reset", 3'b111, 0, 1, 0, 0, 0);
      sys_rst_n = 1'b1;
      foreach (tbl[i]) begin
         trig = tbl[i].t;
         pll = tbl[i].p;
         repeat (tbl[i].n) step();
         chk_all($sformatf("vec%0d", i), tbl[i].r3, tbl[i].d3, tbl[i].r1, tbl[i].d1, 0, 0);
      end
      // abort on the very edge where channel 1 would be released
      repeat (3) step();
      chk_all("pre_collide", 3'b110, 0, 0, 1, 0, 0);
      trig = 1'b1;
      step();
      chk_all("collide", 3'b111, 0, 1, 0, 0, 0);
      trig = 1'b0;
      #2 sys_rst_n = 1'b0;
      #1 chk_all("async_rst", 3'b111, 0, 1, 0, 0, 0);
      kick = 1'b0;
      step();
      sys_rst_n = 1'b1;
      m3 = '{1'b1, 0, 0, 1'b0};
      m1 = m3;
      p1 = 1'b0;
      p2 = 1'b0;
      for (int c = 0; c < 3000; c++) begin
         if ($urandom_range(0, 99) < (pll ? 2 : 8)) pll = ~pll;
         trig = $urandom_range(0, 79) == 0;
         kick = $urandom_range(0, 19) == 0;
         step();
         e++;
         ab = trig | ~p2;
         p2 = p1;
         p1 = pll;
         m3 = mstep(m3, ab, kick, e, 3, HOLD, GAP);
         m1 = mstep(m1, ab, kick, e, 1, 1, 1);
         e3 = mrst(m3, 3, HOLD, GAP);
         chk_all($sformatf("rand%0d", c), e3, mdone(m3, 3, HOLD, GAP), mrst(m1, 1, 1, 1) == 3'b001,
                 mdone(m1, 1, 1, 1), m3.fired, m1.fired);
      end
`ifdef RST_SEQ_WATCHDOG_EN
      trig = 1'b0;
      kick = 1'b0;
      pll = 1'b1;
      sys_rst_n = 1'b0;
      step();
      sys_rst_n = 1'b1;
      wait_done("wd_first_done");
      repeat (15) step();
      chk("wd_pre_rst", 32'(b3.rst_out), 32'd0);
      chk("wd_pre_fired", 32'(b3.wdt_fired), 32'd0);
      step();
      chk("wd_exp_rst", 32'(b3.rst_out), 32'h7);
      chk("wd_exp_fired", 32'(b3.wdt_fired), 32'd1);
      wait_done("wd_second_done");
      chk("wd_sticky", 32'(b3.wdt_fired), 32'd1);
      for (int i = 0; i < 4; i++) begin
         repeat (9) step();
         kick = 1'b1;
         step();
         kick = 1'b0;
      end
      chk("wd_kicked_rst", 32'(b3.rst_out), 32'd0);
      chk("wd_kicked_done", 32'(b3.done), 32'd1);
`endif
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule
